// File: rtl/midi_pkg.sv
// Shared MIDI types and constants for the message sequencer: status-byte
// ranges, message record, parser/writer state encodings.
package midi_pkg;

  localparam logic [7:0] CH_STATUS_MIN  = 8'h80;
  localparam logic [7:0] ONE_BYTE_MIN   = 8'hC0;
  localparam logic [7:0] ONE_BYTE_END   = 8'hE0;
  localparam logic [7:0] SYS_COMMON_MIN = 8'hF0;
  localparam logic [7:0] REALTIME_MIN   = 8'hF8;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] d1;
    logic [7:0] d2;
  } midi_msg_t;

  typedef enum logic [1:0] {
    P_WAIT_STATUS,
    P_WAIT_D1,
    P_WAIT_D2
  } parser_state_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_WR_D1,
    W_WR_D2,
    W_WR_STATUS,
    W_DONE
  } writer_state_t;

  // Program change (0xCn) and channel pressure (0xDn) carry one data byte.
  function automatic logic [1:0] data_count(input logic [7:0] status);
    if (status >= ONE_BYTE_MIN && status < ONE_BYTE_END) begin
      return 2'd1;
    end
    return 2'd2;
  endfunction

endpackage

// File: rtl/midi_msg_fifo.sv
// Synchronous FIFO of completed MIDI messages; a push while full is accepted
// only when a pop happens in the same cycle.
module midi_msg_fifo
  import midi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  midi_msg_t push_data,
  input  logic      pop,
  output midi_msg_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  midi_msg_t     mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/midi_msg_sequencer.sv
// Parses the MIDI RX byte stream into channel messages, queues them, and
// replays each as note, velocity, then status writes on an Avalon-MM master.
module midi_msg_sequencer
  import midi_pkg::*;
#(
  parameter int                FIFO_DEPTH  = 4,
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = 'h00,
  parameter logic [ADDR_W-1:0] NOTE_ADDR   = 'h04,
  parameter logic [ADDR_W-1:0] VEL_ADDR    = 'h08
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic              msg_strobe,
  output logic [7:0]        running_status,
  output logic              overflow
);

  parser_state_t parser_state_q, parser_state_d;
  logic [7:0]    running_status_q, running_status_d;
  logic [7:0]    d1_q, d1_d;
  logic          push_q, push_d;
  midi_msg_t     push_msg_q, push_msg_d;

  writer_state_t     wr_state_q, wr_state_d;
  midi_msg_t         hold_q, hold_d;
  logic              avm_write_q, avm_write_d;
  logic [ADDR_W-1:0] avm_address_q, avm_address_d;
  logic [31:0]       avm_writedata_q, avm_writedata_d;
  logic              msg_strobe_q, msg_strobe_d;
  logic              overflow_q, overflow_d;

  logic      fifo_pop;
  logic      fifo_full;
  logic      fifo_empty;
  midi_msg_t fifo_head;
  logic      accepted;

  // Real-time bytes fall through untouched so they can interleave anywhere.
  always_comb begin
    parser_state_d   = parser_state_q;
    running_status_d = running_status_q;
    d1_d             = d1_q;
    push_d           = 1'b0;
    push_msg_d       = push_msg_q;
    if (rx_valid && rx_data < REALTIME_MIN) begin
      if (rx_data >= SYS_COMMON_MIN) begin
        running_status_d = 8'h00;
        parser_state_d   = P_WAIT_STATUS;
      end else if (rx_data >= CH_STATUS_MIN) begin
        running_status_d = rx_data;
        parser_state_d   = P_WAIT_D1;
      end else begin
        case (parser_state_q)
          P_WAIT_D1: begin
            if (data_count(running_status_q) == 2'd1) begin
              push_d     = 1'b1;
              push_msg_d = '{status: running_status_q, d1: rx_data, d2: 8'h00};
            end else begin
              d1_d           = rx_data;
              parser_state_d = P_WAIT_D2;
            end
          end
          P_WAIT_D2: begin
            push_d         = 1'b1;
            push_msg_d     = '{status: running_status_q, d1: d1_q, d2: rx_data};
            parser_state_d = P_WAIT_D1;
          end
          default: parser_state_d = parser_state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parser_state_q   <= P_WAIT_STATUS;
      running_status_q <= 8'h00;
      d1_q             <= 8'h00;
      push_q           <= 1'b0;
      push_msg_q       <= '0;
    end else begin
      parser_state_q   <= parser_state_d;
      running_status_q <= running_status_d;
      d1_q             <= d1_d;
      push_q           <= push_d;
      push_msg_q       <= push_msg_d;
    end
  end

  midi_msg_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_q),
    .push_data(push_msg_q),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign accepted = avm_write_q && !avm_waitrequest;

  // Bus outputs are registered, so each state computes the next write's fields.
  always_comb begin
    wr_state_d      = wr_state_q;
    hold_d          = hold_q;
    avm_write_d     = avm_write_q;
    avm_address_d   = avm_address_q;
    avm_writedata_d = avm_writedata_q;
    msg_strobe_d    = 1'b0;
    fifo_pop        = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop        = 1'b1;
          hold_d          = fifo_head;
          wr_state_d      = W_WR_D1;
          avm_write_d     = 1'b1;
          avm_address_d   = NOTE_ADDR;
          avm_writedata_d = {24'h0, fifo_head.d1};
        end
      end
      W_WR_D1: begin
        if (accepted) begin
          wr_state_d      = W_WR_D2;
          avm_address_d   = VEL_ADDR;
          avm_writedata_d = {24'h0, hold_q.d2};
        end
      end
      W_WR_D2: begin
        if (accepted) begin
          wr_state_d      = W_WR_STATUS;
          avm_address_d   = STATUS_ADDR;
          avm_writedata_d = {24'h0, hold_q.status};
        end
      end
      W_WR_STATUS: begin
        if (accepted) begin
          wr_state_d      = W_DONE;
          avm_write_d     = 1'b0;
          avm_address_d   = '0;
          avm_writedata_d = 32'h0;
          msg_strobe_d    = 1'b1;
        end
      end
      W_DONE:  wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  assign overflow_d = overflow_q | (push_q && fifo_full && !fifo_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state_q      <= W_IDLE;
      hold_q          <= '0;
      avm_write_q     <= 1'b0;
      avm_address_q   <= '0;
      avm_writedata_q <= 32'h0;
      msg_strobe_q    <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      wr_state_q      <= wr_state_d;
      hold_q          <= hold_d;
      avm_write_q     <= avm_write_d;
      avm_address_q   <= avm_address_d;
      avm_writedata_q <= avm_writedata_d;
      msg_strobe_q    <= msg_strobe_d;
      overflow_q      <= overflow_d;
    end
  end

  assign avm_address    = avm_address_q;
  assign avm_write      = avm_write_q;
  assign avm_writedata  = avm_writedata_q;
  assign msg_strobe     = msg_strobe_q;
  assign running_status = running_status_q;
  assign overflow       = overflow_q;

endmodule
